// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer and instruction-memory fetch front end
// for the RV32I pipeline.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-high reset
//   redirect_i     taken branch/jump from EX (single-cycle pulse)
//   redirect_pc_i  redirect target
//   stall_i        hazard stall; IF/ID holds its contents
//   imem_req_o     fetch request, held with imem_addr_o until acked
//   imem_addr_o    fetch address
//   imem_ack_i     response valid, imem_rdata_i valid in the same cycle
//   imem_rdata_i   instruction word
//   if_valid_o     output register holds an instruction
//   if_pc_o        PC of the presented instruction
//   if_pc4_o       if_pc_o + 4
//   if_instr_o     presented instruction
//   flush_o        clear IF/ID (mirrors redirect_i)
//   misalign_o     one-cycle pulse: previous redirect target was not word aligned
//
// At most one request is outstanding. A request is only launched when the
// response is guaranteed a slot (output register or skid), so a response is
// never dropped while stalled.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          ALIGN_MASK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_instr_o,
  output logic        flush_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;           // next address to fetch
  logic [31:0] addr_q, addr_d;       // address of the outstanding request
  logic        req_q, req_d;
  logic        out_v_q, out_v_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        mis_q, mis_d;

  logic        ack_v;
  logic        consume;
  logic        keep;
  logic        pend;
  logic        out_free;
  logic        launch;
  logic [31:0] tgt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    req_d        = req_q;
    out_v_d      = out_v_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    ack_v   = req_q & imem_ack_i;
    consume = out_v_q & ~stall_i;
    // Responses in DRAIN, or in the cycle of a redirect, belong to the
    // flushed path and are dropped.
    keep    = ack_v & (state_q == REQ) & ~redirect_i;
    pend    = req_q & ~imem_ack_i;
    tgt     = ALIGN_MASK ? {redirect_pc_i[31:2], 2'b00} : redirect_pc_i;
    mis_d   = ALIGN_MASK & redirect_i & (redirect_pc_i[1:0] != 2'b00);

    unique case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (redirect_i && pend) state_d = DRAIN;
      DRAIN:   if (imem_ack_i) state_d = REQ;
      default: state_d = IDLE;
    endcase

    if (redirect_i) begin
      pc_d = tgt;
    end else if (keep) begin
      pc_d = pc_q + 32'd4;
    end

    if (redirect_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || consume) begin
      if (skid_v_q) begin
        out_v_d     = 1'b1;
        out_pc_d    = skid_pc_q;
        out_instr_d = skid_instr_q;
        skid_v_d    = keep;
        if (keep) begin
          skid_pc_d    = addr_q;
          skid_instr_d = imem_rdata_i;
        end
      end else if (keep) begin
        out_v_d     = 1'b1;
        out_pc_d    = addr_q;
        out_instr_d = imem_rdata_i;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (keep) begin
      skid_v_d     = 1'b1;
      skid_pc_d    = addr_q;
      skid_instr_d = imem_rdata_i;
    end

    // A new request needs a free skid after this edge so its response,
    // arriving at the earliest next cycle, always has somewhere to land.
    out_free = redirect_i | ~out_v_q | consume;
    launch   = (state_d == REQ) & ~pend & ~skid_v_d & out_free;
    req_d    = pend | launch;
    if (launch) begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      out_v_q     <= 1'b0;
      out_pc_q    <= 32'd0;
      out_instr_q <= 32'd0;
      skid_v_q    <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      out_v_q     <= out_v_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      skid_v_q    <= skid_v_d;
      mis_q       <= mis_d;
    end
  end

  // Skid payload is qualified by skid_v_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    skid_pc_q    <= skid_pc_d;
    skid_instr_q <= skid_instr_d;
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = out_v_q;
  assign if_pc_o     = out_pc_q;
  assign if_pc4_o    = out_pc_q + 32'd4;
  assign if_instr_o  = out_instr_q;
  assign flush_o     = redirect_i;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: variable-latency memory model, stall/redirect
// stimulus, and a scoreboard of expected {pc, instr} pushed as the memory
// answers and popped when IF/ID consumes an instruction.
module tb_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc4_o;
  logic [31:0] if_instr_o;
  logic        flush_o;
  logic        misalign_o;

  fetch_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_pc4_o     (if_pc4_o),
    .if_instr_o   (if_instr_o),
    .flush_o      (flush_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int lat;
    int sf;
    int sl;
    int n;
    int first_c;
    int last_c;
    int qf;
    int qt;
  } row_t;

  exp_t        sbq[$];
  row_t        rows[5];
  int          total, bad;
  int          cyc, lat, wcnt;
  int          ncons, first_c, last_c;
  int          q_from, q_to;
  logic [31:0] held_addr, exp_pc;
  bit          draining, junk_ack, exp_mis;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input bit st, input bit rd, input logic [31:0] rpc);
    bit   ack;
    exp_t e;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    ack           = 1'b0;
    if (imem_req_o === 1'b1) begin
      if (wcnt == 0) begin
        held_addr = imem_addr_o;
        if (!draining) check32("req_addr", imem_addr_o, exp_pc);
      end else begin
        check32("addr_stable", imem_addr_o, held_addr);
      end
      ack          = (wcnt >= lat);
      imem_ack_i   = ack;
      imem_rdata_i = mem_fn(imem_addr_o);
    end else begin
      if (wcnt > 0) check32("req_held", {31'b0, imem_req_o}, 32'd1);
      imem_ack_i   = junk_ack;
      imem_rdata_i = 32'hDEAD_BEEF;
    end
    if (cyc >= q_from && cyc <= q_to) check32("req_quiet", {31'b0, imem_req_o}, 32'd0);
    #1;
    check32("flush", {31'b0, flush_o}, {31'b0, rd});
    check32("misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
    if (if_valid_o === 1'b1 && !st && !rd) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc %h expected no instruction (cycle %0d)", if_pc_o, cyc);
      end else begin
        e = sbq.pop_front();
        check32("if_pc", if_pc_o, e.pc);
        check32("if_pc4", if_pc4_o, e.pc + 32'd4);
        check32("if_instr", if_instr_o, e.instr);
      end
      ncons++;
      if (first_c < 0) first_c = cyc;
      last_c = cyc;
    end
    if (ack) begin
      if (rd || draining) begin
        draining = 1'b0;
      end else begin
        e.pc    = exp_pc;
        e.instr = mem_fn(exp_pc);
        sbq.push_back(e);
        exp_pc  = exp_pc + 32'd4;
      end
    end
    exp_mis = rd && (rpc[1:0] != 2'b00);
    if (rd) begin
      sbq.delete();
      exp_pc = rpc & 32'hFFFF_FFFC;
      if (imem_req_o === 1'b1 && !ack) draining = 1'b1;
    end
    wcnt = (imem_req_o === 1'b1 && !ack) ? wcnt + 1 : 0;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = 32'd0;
    repeat (2) @(negedge clk_i);
    check32("rst_req", {31'b0, imem_req_o}, 32'd0);
    check32("rst_addr", imem_addr_o, 32'h0000_0000);
    check32("rst_valid", {31'b0, if_valid_o}, 32'd0);
    check32("rst_pc", if_pc_o, 32'd0);
    check32("rst_instr", if_instr_o, 32'd0);
    check32("rst_misalign", {31'b0, misalign_o}, 32'd0);
    rst_i    = 1'b0;
    cyc      = 0;
    wcnt     = 0;
    draining = 1'b0;
    junk_ack = 1'b0;
    exp_mis  = 1'b0;
    exp_pc   = 32'h0000_0000;
    sbq.delete();
    ncons    = 0;
    first_c  = -1;
    last_c   = -1;
    q_from   = 1;
    q_to     = 0;
  endtask

  // Run until n instructions are consumed; stall_i is high in [sf, sf+sl).
  task automatic run_n(input int n, input int sf, input int sl);
    int it;
    it = 0;
    while (ncons < n && it < 80) begin
      tick((cyc >= sf) && (cyc < sf + sl), 1'b0, 32'd0);
      it++;
    end
    total++;
    if (ncons < n) begin
      bad++;
      $display("FAIL timeout: got %0d outputs expected %0d", ncons, n);
    end
  endtask

  initial begin
    int it;
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = 32'd0;
    total         = 0;
    bad           = 0;
    cyc           = 0;
    lat           = 0;
    wcnt          = 0;
    @(negedge clk_i);

    //          lat  sf  sl  n  first last qf  qt
    rows[0] = '{0,   99, 0,  3, 2,    4,   1,  0};
    rows[1] = '{3,   99, 0,  3, 5,    13,  1,  0};
    rows[2] = '{0,   4,  5,  5, 2,    11,  5,  9};
    rows[3] = '{1,   99, 0,  3, 3,    7,   1,  0};
    rows[4] = '{2,   6,  4,  4, 4,    14,  10, 10};

    for (int r = 0; r < 5; r++) begin
      do_reset();
      lat    = rows[r].lat;
      q_from = rows[r].qf;
      q_to   = rows[r].qt;
      run_n(rows[r].n, rows[r].sf, rows[r].sl);
      check32("first_out_cycle", first_c, rows[r].first_c);
      check32("last_out_cycle", last_c, rows[r].last_c);
      q_from = 1;
      q_to   = 0;
    end

    // Redirect while the 0x20 request is outstanding:
    // v0 plain, v1 with stall, v2 second redirect while draining.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      lat = (v == 2) ? 3 : 2;
      it  = 0;
      while (!(imem_req_o === 1'b1 && imem_addr_o == 32'h20 && wcnt == 1) && it < 200) begin
        tick(1'b0, 1'b0, 32'd0);
        it++;
      end
      total++;
      if (it >= 200) begin
        bad++;
        $display("FAIL wait_0x20: got no pending request expected one at 00000020");
      end
      tick(v == 1, 1'b1, 32'h1234_5600);
      if (v == 2) tick(1'b0, 1'b1, 32'h1234_5700);
      ncons = 0;
      run_n(3, 999, 0);
    end

    // Misaligned target, then wrap-around at the top of the address space.
    do_reset();
    lat = 0;
    run_n(2, 999, 0);
    tick(1'b0, 1'b1, 32'h8765_4302);
    check32("misalign_pulse", {31'b0, misalign_o}, 32'd1);
    ncons = 0;
    run_n(3, 999, 0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    ncons = 0;
    run_n(3, 999, 0);

    // Asynchronous reset in the middle of a wait, then a stray ack.
    do_reset();
    lat = 3;
    while (cyc < 6) tick(cyc >= 5, 1'b0, 32'd0);
    check32("pre_rst_req", {31'b0, imem_req_o}, 32'd1);
    check32("pre_rst_valid", {31'b0, if_valid_o}, 32'd1);
    rst_i      = 1'b1;
    imem_ack_i = 1'b1;
    #1;
    check32("async_rst_req", {31'b0, imem_req_o}, 32'd0);
    check32("async_rst_valid", {31'b0, if_valid_o}, 32'd0);
    do_reset();
    lat      = 0;
    junk_ack = 1'b1;
    tick(1'b0, 1'b0, 32'd0);
    junk_ack = 1'b0;
    run_n(2, 999, 0);
    check32("restart_first_cycle", first_c, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
